// File: rtl/mem_port_arbiter.sv
// Arbitrates the I-cache and D-cache line-fill requests onto a single memory port and streams
// the response beats back to the winner. Define ARB_DCACHE_PRIORITY_EN for fixed D-cache priority.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 58,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BEATS      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_line_addr,
  output logic                  ic_grant,
  output logic                  ic_beat_valid,
  output logic                  ic_done,
  input  logic                  dc_req,
  input  logic [ADDR_WIDTH-1:0] dc_line_addr,
  output logic                  dc_grant,
  output logic                  dc_beat_valid,
  output logic                  dc_done,
  output logic [DATA_WIDTH-1:0] beat_data,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_line_addr,
  input  logic                  mem_accept,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic                  arb_err
);

  localparam int unsigned CntW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StRecv, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  gnt_ic_q, gnt_ic_d;
  logic                  gnt_dc_q, gnt_dc_d;
  logic                  last_dc_q, last_dc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ic_bv_q, ic_bv_d;
  logic                  dc_bv_q, dc_bv_d;
  logic                  ic_done_q, ic_done_d;
  logic                  dc_done_q, dc_done_d;
  logic                  err_q, err_d;
  logic                  pick_dc;

  always_comb begin
    pick_dc = 1'b0;
`ifdef ARB_DCACHE_PRIORITY_EN
    pick_dc = dc_req;
`else
    // On a tie the requester that did not win last time goes next.
    pick_dc = dc_req && (!ic_req || !last_dc_q);
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_ic_d  = gnt_ic_q;
    gnt_dc_d  = gnt_dc_q;
    last_dc_d = last_dc_q;
    addr_d    = addr_q;
    data_d    = data_q;
    ic_bv_d   = 1'b0;
    dc_bv_d   = 1'b0;
    ic_done_d = 1'b0;
    dc_done_d = 1'b0;
    err_d     = err_q;

    // Beats outside a fill are dropped and flagged until reset.
    if (mem_resp_valid && (state_q != StRecv)) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (ic_req || dc_req) begin
          gnt_ic_d = !pick_dc;
          gnt_dc_d = pick_dc;
          addr_d   = pick_dc ? dc_line_addr : ic_line_addr;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (mem_accept) begin
          cnt_d   = '0;
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (mem_resp_valid) begin
          data_d  = mem_resp_data;
          ic_bv_d = gnt_ic_q;
          dc_bv_d = gnt_dc_q;
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StDone: begin
        ic_done_d = gnt_ic_q;
        dc_done_d = gnt_dc_q;
        last_dc_d = gnt_dc_q;
        gnt_ic_d  = 1'b0;
        gnt_dc_d  = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      gnt_ic_q  <= 1'b0;
      gnt_dc_q  <= 1'b0;
      last_dc_q <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
      ic_bv_q   <= 1'b0;
      dc_bv_q   <= 1'b0;
      ic_done_q <= 1'b0;
      dc_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_ic_q  <= gnt_ic_d;
      gnt_dc_q  <= gnt_dc_d;
      last_dc_q <= last_dc_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ic_bv_q   <= ic_bv_d;
      dc_bv_q   <= dc_bv_d;
      ic_done_q <= ic_done_d;
      dc_done_q <= dc_done_d;
      err_q     <= err_d;
    end
  end

  assign ic_grant      = gnt_ic_q;
  assign dc_grant      = gnt_dc_q;
  assign ic_beat_valid = ic_bv_q;
  assign dc_beat_valid = dc_bv_q;
  assign ic_done       = ic_done_q;
  assign dc_done       = dc_done_q;
  assign beat_data     = data_q;
  assign mem_req       = (state_q == StIssue);
  assign mem_line_addr = addr_q;
  assign arb_err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter; expected winners, beats and done timing
// come from a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int AW = 58;
  localparam int DW = 64;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req, dc_req;
  logic [AW-1:0] ic_line_addr, dc_line_addr;
  logic          ic_grant, ic_beat_valid, ic_done;
  logic          dc_grant, dc_beat_valid, dc_done;
  logic [DW-1:0] beat_data;
  logic          mem_req;
  logic [AW-1:0] mem_line_addr;
  logic          mem_accept, mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic          arb_err;

  int checks = 0;
  int errors = 0;
  bit model_last_dc;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(NB)) dut (
    .clk            (clk),
    .reset          (reset),
    .ic_req         (ic_req),
    .ic_line_addr   (ic_line_addr),
    .ic_grant       (ic_grant),
    .ic_beat_valid  (ic_beat_valid),
    .ic_done        (ic_done),
    .dc_req         (dc_req),
    .dc_line_addr   (dc_line_addr),
    .dc_grant       (dc_grant),
    .dc_beat_valid  (dc_beat_valid),
    .dc_done        (dc_done),
    .beat_data      (beat_data),
    .mem_req        (mem_req),
    .mem_line_addr  (mem_line_addr),
    .mem_accept     (mem_accept),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .arb_err        (arb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end, want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[AW-1:0];
  endfunction

  // Arbitration rule: single request wins; on a tie the non-last winner goes (or DC on priority).
  function automatic bit exp_winner_dc(input bit ic, input bit dc);
`ifdef ARB_DCACHE_PRIORITY_EN
    return dc;
`else
    if (ic && dc) return !model_last_dc;
    return dc;
`endif
  endfunction

  // Runs one fill; requests must already be driven. Returns in the cycle the done pulse is visible.
  task automatic do_fill(input bit exp_dc, input logic [AW-1:0] exp_addr, input int stall,
                         input bit gappy, input bit seq_data);
    logic [DW-1:0] d;
    logic          v;
    int            sent;
    int            budget;
    tick();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL mem_req_issue: got %b want 1", mem_req);
    end
    checks++;
    if (ic_grant !== !exp_dc || dc_grant !== exp_dc) begin
      errors++; $display("FAIL grant_winner: ic=%b dc=%b want dc=%b", ic_grant, dc_grant, exp_dc);
    end
    checks++;
    if (mem_line_addr !== exp_addr) begin
      errors++; $display("FAIL mem_line_addr: got %h want %h", mem_line_addr, exp_addr);
    end
    checks++;
    if ((ic_done | dc_done) !== 1'b0) begin
      errors++; $display("FAIL done_one_cycle: ic=%b dc=%b want 0", ic_done, dc_done);
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      checks++;
      if (mem_req !== 1'b1 || mem_line_addr !== exp_addr || dc_grant !== exp_dc) begin
        errors++;
        $display("FAIL stall_hold: req=%b addr=%h dc_grant=%b want 1 %h %b",
                 mem_req, mem_line_addr, dc_grant, exp_addr, exp_dc);
      end
    end
    mem_accept = 1'b1;
    tick();
    mem_accept = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL mem_req_after_accept: got %b want 0", mem_req);
    end
    sent = 0;
    budget = 0;
    while (sent < NB && budget < 400) begin
      v = gappy ? ($urandom_range(2) == 0) : 1'b1;
      d = seq_data ? DW'(sent) : {$urandom(), $urandom()};
      mem_resp_valid = v;
      mem_resp_data  = d;
      tick();
      budget++;
      checks++;
      if ((exp_dc ? dc_beat_valid : ic_beat_valid) !== v ||
          (exp_dc ? ic_beat_valid : dc_beat_valid) !== 1'b0) begin
        errors++;
        $display("FAIL beat_valid: ic=%b dc=%b want %b to dc=%b",
                 ic_beat_valid, dc_beat_valid, v, exp_dc);
      end
      if (v) begin
        checks++;
        if (beat_data !== d) begin
          errors++; $display("FAIL beat_data: got %h want %h", beat_data, d);
        end
        sent++;
      end
      checks++;
      if ((ic_done | dc_done) !== 1'b0 || dc_grant !== exp_dc || ic_grant !== !exp_dc) begin
        errors++;
        $display("FAIL recv_hold: done=%b%b grant=%b%b want done 00 dc_grant=%b",
                 ic_done, dc_done, ic_grant, dc_grant, exp_dc);
      end
    end
    mem_resp_valid = 1'b0;
    if (budget >= 400) begin
      checks++; errors++;
      $display("FAIL beat_budget: sent %0d beats want %0d", sent, NB);
    end
    tick();
    checks++;
    if (dc_done !== exp_dc || ic_done !== !exp_dc) begin
      errors++; $display("FAIL done_pulse: ic=%b dc=%b want dc=%b", ic_done, dc_done, exp_dc);
    end
    checks++;
    if (ic_grant !== 1'b0 || dc_grant !== 1'b0 || ic_beat_valid !== 1'b0 ||
        dc_beat_valid !== 1'b0 || arb_err !== 1'b0) begin
      errors++;
      $display("FAIL done_cleanup: grant=%b%b bv=%b%b err=%b want all 0",
               ic_grant, dc_grant, ic_beat_valid, dc_beat_valid, arb_err);
    end
    model_last_dc = exp_dc;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_last_dc = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_last_dc = 1'b1;
    checks++;
    if ({ic_grant, dc_grant, ic_beat_valid, dc_beat_valid, ic_done, dc_done, mem_req, arb_err}
        !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000000",
               {ic_grant, dc_grant, ic_beat_valid, dc_beat_valid, ic_done, dc_done, mem_req,
                arb_err});
    end
    checks++;
    if (mem_line_addr !== '0 || beat_data !== '0) begin
      errors++; $display("FAIL reset_buses: addr=%h data=%h want 0", mem_line_addr, beat_data);
    end
  endtask

  task automatic test_single_fill();
    ic_line_addr = AW'(16);
    ic_req = 1'b1;
    do_fill(1'b0, AW'(16), 0, 1'b0, 1'b1);
    ic_req = 1'b0;
    tick();
    checks++;
    if (ic_done !== 1'b0 || ic_grant !== 1'b0) begin
      errors++; $display("FAIL single_after_done: done=%b grant=%b want 0 0", ic_done, ic_grant);
    end
  endtask

  task automatic test_round_robin();
    bit w;
    int n_dc;
    apply_reset();
    ic_line_addr = rand_addr();
    dc_line_addr = rand_addr();
    ic_req = 1'b1;
    dc_req = 1'b1;
    n_dc = 0;
    for (int i = 0; i < 3; i++) begin
      w = exp_winner_dc(1'b1, 1'b1);
      n_dc += int'(w);
      do_fill(w, w ? dc_line_addr : ic_line_addr, 0, 1'b0, 1'b0);
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
`ifdef ARB_DCACHE_PRIORITY_EN
    checks++;
    if (n_dc != 3) begin
      errors++; $display("FAIL priority_count: dc wins %0d want 3", n_dc);
    end
`else
    checks++;
    if (n_dc != 1) begin
      errors++; $display("FAIL rr_alternation: dc wins %0d want 1", n_dc);
    end
`endif
  endtask

  task automatic test_accept_stall();
    dc_line_addr = rand_addr();
    dc_req = 1'b1;
    do_fill(exp_winner_dc(1'b0, 1'b1), dc_line_addr, 5, 1'b0, 1'b0);
    dc_req = 1'b0;
  endtask

  task automatic test_gaps();
    ic_line_addr = rand_addr();
    ic_req = 1'b1;
    do_fill(exp_winner_dc(1'b1, 1'b0), ic_line_addr, 1, 1'b1, 1'b0);
    ic_req = 1'b0;
  endtask

  task automatic test_spurious();
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = {$urandom(), $urandom()};
    tick();
    mem_resp_valid = 1'b0;
    checks++;
    if (arb_err !== 1'b1 || ic_beat_valid !== 1'b0 || dc_beat_valid !== 1'b0) begin
      errors++;
      $display("FAIL spurious_beat: err=%b bv=%b%b want 1 00", arb_err, ic_beat_valid,
               dc_beat_valid);
    end
    repeat (3) tick();
    checks++;
    if (arb_err !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b want 1", arb_err);
    end
    apply_reset();
    checks++;
    if (arb_err !== 1'b0) begin
      errors++; $display("FAIL err_reset: got %b want 0", arb_err);
    end
  endtask

  task automatic test_mid_reset();
    ic_line_addr = rand_addr();
    ic_req = 1'b1;
    tick();
    mem_accept = 1'b1;
    tick();
    mem_accept = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = {$urandom(), $urandom()};
      tick();
    end
    mem_resp_valid = 1'b0;
    ic_req = 1'b0;
    apply_reset();
    checks++;
    if ({ic_grant, dc_grant, ic_beat_valid, dc_beat_valid, ic_done, dc_done, mem_req, arb_err}
        !== 8'h00 || mem_line_addr !== '0 || beat_data !== '0) begin
      errors++;
      $display("FAIL mid_reset_clear: flags=%b addr=%h data=%h want all 0",
               {ic_grant, dc_grant, ic_beat_valid, dc_beat_valid, ic_done, dc_done, mem_req,
                arb_err}, mem_line_addr, beat_data);
    end
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    checks++;
    if (arb_err !== 1'b1 || ic_beat_valid !== 1'b0) begin
      errors++; $display("FAIL late_beat: err=%b bv=%b want 1 0", arb_err, ic_beat_valid);
    end
    apply_reset();
    dc_line_addr = rand_addr();
    dc_req = 1'b1;
    do_fill(exp_winner_dc(1'b0, 1'b1), dc_line_addr, 0, 1'b0, 1'b0);
    dc_req = 1'b0;
  endtask

  task automatic test_random();
    int sel;
    bit ic, dc, w;
    for (int i = 0; i < 8; i++) begin
      sel = $urandom_range(3, 1);
      ic = sel[0];
      dc = sel[1];
      ic_line_addr = rand_addr();
      dc_line_addr = rand_addr();
      ic_req = ic;
      dc_req = dc;
      w = exp_winner_dc(ic, dc);
      do_fill(w, w ? dc_line_addr : ic_line_addr, $urandom_range(3), 1'b1, 1'b0);
      ic_req = 1'b0;
      dc_req = 1'b0;
    end
  endtask

  initial begin
    reset          = 1'b1;
    ic_req         = 1'b0;
    dc_req         = 1'b0;
    ic_line_addr   = '0;
    dc_line_addr   = '0;
    mem_accept     = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    model_last_dc  = 1'b1;
    test_reset();
    test_single_fill();
    test_round_robin();
    test_accept_stall();
    test_gaps();
    test_spurious();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
